// File: rtl/gate_test_mem_responder.sv
// gate_test_mem_responder
// Memory-side responder for the gate-test controller. A write command fills an
// inclusive address window of a small byte memory from UART receive bytes; a
// read command streams the same kind of window back out under valid/ready.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cmd, cmd_valid    command code (00 read, 01 write) and its one-cycle strobe
//   start_addr        first window address (inclusive)
//   end_addr          last window address (inclusive)
//   rx_byte, rx_valid UART receive byte and its one-cycle strobe
//   tx_ready          downstream can accept tx_byte
//   tx_byte, tx_valid read data and its qualifier
//   rx_done, tx_done  one-cycle completion pulses for write / read
//   busy              transfer in progress (through the done-pulse cycle)
//   err               one-cycle pulse on a rejected command
module gate_test_mem_responder #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned IDX_W  = $clog2(DEPTH),
    localparam int unsigned ADDR_W = 16,
    localparam int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        cmd,
    input  logic              cmd_valid,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic [DATA_W-1:0] rx_byte,
    input  logic              rx_valid,
    input  logic              tx_ready,
    output logic [DATA_W-1:0] tx_byte,
    output logic              tx_valid,
    output logic              rx_done,
    output logic              tx_done,
    output logic              busy,
    output logic              err
);

    localparam logic [7:0] CMD_READ  = 8'h00;
    localparam logic [7:0] CMD_WRITE = 8'h01;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE      = 2'd1,
        RD_FETCH   = 2'd2,
        RD_PRESENT = 2'd3
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  end_idx;
    logic [DATA_W-1:0] mem [DEPTH];

    logic win_ok_c;
    logic cmd_ok_c;
    logic mem_we_c;

    // Window check at full address width so out-of-range upper bits reject.
    assign win_ok_c = (end_addr >= start_addr) && (end_addr <= ADDR_W'(DEPTH - 1));
    assign cmd_ok_c = (cmd == CMD_READ) || (cmd == CMD_WRITE);
    // A reset edge must not commit a byte from the abandoned transfer.
    assign mem_we_c = !rst && (state == WRITE) && rx_valid;

    // Byte storage; intentionally not cleared by reset.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[ptr] <= rx_byte;
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            end_idx  <= '0;
            tx_byte  <= '0;
            tx_valid <= 1'b0;
            rx_done  <= 1'b0;
            tx_done  <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            tx_done <= 1'b0;
            err     <= 1'b0;
            case (state)
                IDLE: begin
                    // busy drops one cycle after the done pulse.
                    busy <= 1'b0;
                    if (cmd_valid) begin
                        if (cmd_ok_c && win_ok_c) begin
                            ptr     <= start_addr[IDX_W-1:0];
                            end_idx <= end_addr[IDX_W-1:0];
                            busy    <= 1'b1;
                            state   <= (cmd == CMD_WRITE) ? WRITE : RD_FETCH;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (rx_valid) begin
                        if (ptr == end_idx) begin
                            rx_done <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            ptr <= ptr + IDX_W'(1);
                        end
                    end
                end
                RD_FETCH: begin
                    tx_byte  <= mem[ptr];
                    tx_valid <= 1'b1;
                    state    <= RD_PRESENT;
                end
                RD_PRESENT: begin
                    if (tx_valid && tx_ready) begin
                        tx_valid <= 1'b0;
                        if (ptr == end_idx) begin
                            tx_done <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            ptr   <= ptr + IDX_W'(1);
                            state <= RD_FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_test_mem_responder.sv
// Directed testbench for gate_test_mem_responder.
module tb_gate_test_mem_responder;

    logic        clk;
    logic        rst;
    logic [7:0]  cmd;
    logic        cmd_valid;
    logic [15:0] start_addr;
    logic [15:0] end_addr;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        tx_ready;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        rx_done;
    logic        tx_done;
    logic        busy;
    logic        err;

    int errors = 0;
    int checks = 0;

    gate_test_mem_responder dut (
        .clk        (clk),
        .rst        (rst),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .start_addr (start_addr),
        .end_addr   (end_addr),
        .rx_byte    (rx_byte),
        .rx_valid   (rx_valid),
        .tx_ready   (tx_ready),
        .tx_byte    (tx_byte),
        .tx_valid   (tx_valid),
        .rx_done    (rx_done),
        .tx_done    (tx_done),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a command for one sampling edge.
    task automatic do_cmd(input logic [7:0] c, input logic [15:0] s, input logic [15:0] e);
        cmd        = c;
        start_addr = s;
        end_addr   = e;
        cmd_valid  = 1'b1;
        tick();
        cmd_valid  = 1'b0;
    endtask

    // Write n bytes (byte i in data[8*i +: 8]) starting at s, with gap idle cycles between.
    task automatic write_window(input string tag, input logic [15:0] s, input int n,
                                input logic [31:0] data, input int gap);
        do_cmd(8'h01, s, s + 16'(n - 1));
        chk({tag, " busy_after_cmd"}, 32'(busy), 32'd1);
        for (int i = 0; i < n; i++) begin
            rx_byte  = data[8*i +: 8];
            rx_valid = 1'b1;
            tick();
            rx_valid = 1'b0;
            chk({tag, " rx_done"}, 32'(rx_done), (i == n - 1) ? 32'd1 : 32'd0);
            chk({tag, " busy"}, 32'(busy), 32'd1);
            if (i != n - 1) begin
                repeat (gap) tick();
            end
        end
        tick();
        chk({tag, " rx_done_width"}, 32'(rx_done), 32'd0);
        chk({tag, " busy_end"}, 32'(busy), 32'd0);
    endtask

    // Read n bytes from s, stalling tx_ready low for stall cycles per byte.
    // With poke set, rx_valid pulses with junk data during each stall cycle.
    task automatic read_window(input string tag, input logic [15:0] s, input int n,
                               input logic [31:0] exp, input int stall, input logic poke);
        tx_ready = (stall == 0);
        do_cmd(8'h00, s, s + 16'(n - 1));
        chk({tag, " fetch_no_valid"}, 32'(tx_valid), 32'd0);
        chk({tag, " busy_after_cmd"}, 32'(busy), 32'd1);
        for (int i = 0; i < n; i++) begin
            tick();
            chk({tag, " tx_valid"}, 32'(tx_valid), 32'd1);
            chk({tag, " tx_byte"}, 32'(tx_byte), 32'(exp[8*i +: 8]));
            for (int k = 0; k < stall; k++) begin
                rx_valid = poke;
                rx_byte  = 8'hEE;
                tick();
                rx_valid = 1'b0;
                chk({tag, " stall_valid"}, 32'(tx_valid), 32'd1);
                chk({tag, " stall_byte"}, 32'(tx_byte), 32'(exp[8*i +: 8]));
            end
            tx_ready = 1'b1;
            tick();
            tx_ready = (stall == 0);
            chk({tag, " valid_drop"}, 32'(tx_valid), 32'd0);
            chk({tag, " tx_done"}, 32'(tx_done), (i == n - 1) ? 32'd1 : 32'd0);
            chk({tag, " busy"}, 32'(busy), 32'd1);
        end
        tick();
        chk({tag, " tx_done_width"}, 32'(tx_done), 32'd0);
        chk({tag, " busy_end"}, 32'(busy), 32'd0);
        tick();
        chk({tag, " no_extra_byte"}, 32'(tx_valid), 32'd0);
        tx_ready = 1'b0;
    endtask

    // Issue a rejected command and confirm the err pulse with busy low.
    task automatic reject(input string tag, input logic [7:0] c, input logic [15:0] s,
                          input logic [15:0] e);
        do_cmd(c, s, e);
        chk({tag, " err"}, 32'(err), 32'd1);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        tick();
        chk({tag, " err_width"}, 32'(err), 32'd0);
        chk({tag, " stays_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        cmd        = 8'h00;
        cmd_valid  = 1'b0;
        start_addr = 16'h0000;
        end_addr   = 16'h0000;
        rx_byte    = 8'h00;
        rx_valid   = 1'b0;
        tx_ready   = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        chk("reset tx_byte", 32'(tx_byte), 32'd0);
        chk("reset tx_valid", 32'(tx_valid), 32'd0);
        chk("reset rx_done", 32'(rx_done), 32'd0);
        chk("reset tx_done", 32'(tx_done), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset err", 32'(err), 32'd0);

        // Single-address write and read at 0x0008.
        write_window("wr8", 16'h0008, 1, 32'h0000_001B, 0);
        read_window("rd8", 16'h0008, 1, 32'h0000_001B, 0, 1'b0);

        // Four-byte window with gaps, then stalled read-back.
        write_window("wr0_3", 16'h0000, 4, 32'hD4C3_B2A1, 2);
        read_window("rd0_3", 16'h0000, 4, 32'hD4C3_B2A1, 3, 1'b0);

        // Rejections: bad opcode, reversed window, window past the end.
        reject("rej_cmd", 8'h05, 16'h0000, 16'h0000);
        reject("rej_rev", 8'h00, 16'h0004, 16'h0002);
        reject("rej_oob", 8'h01, 16'h0000, 16'h0010);
        reject("rej_hi", 8'h01, 16'h0100, 16'h0100);
        read_window("rd_after_rej", 16'h0000, 4, 32'hD4C3_B2A1, 0, 1'b0);
        read_window("rd8_after_rej", 16'h0008, 1, 32'h0000_001B, 0, 1'b0);

        // rx_valid in IDLE is dropped.
        rx_byte  = 8'h55;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        chk("idle_rx busy", 32'(busy), 32'd0);

        // Partial write, ignored second command, then reset with rx_valid high.
        do_cmd(8'h01, 16'h0000, 16'h0003);
        for (int i = 0; i < 2; i++) begin
            rx_byte  = (i == 0) ? 8'hE1 : 8'hE2;
            rx_valid = 1'b1;
            tick();
            rx_valid = 1'b0;
        end
        do_cmd(8'h00, 16'h0008, 16'h0008);
        chk("mid_cmd ignored busy", 32'(busy), 32'd1);
        chk("mid_cmd ignored err", 32'(err), 32'd0);
        chk("mid_cmd no tx_valid", 32'(tx_valid), 32'd0);
        rst      = 1'b1;
        rx_byte  = 8'hE3;
        rx_valid = 1'b1;
        tick();
        rst      = 1'b0;
        rx_valid = 1'b0;
        chk("mid_rst busy", 32'(busy), 32'd0);
        chk("mid_rst tx_valid", 32'(tx_valid), 32'd0);
        chk("mid_rst tx_byte", 32'(tx_byte), 32'd0);
        chk("mid_rst rx_done", 32'(rx_done), 32'd0);
        chk("mid_rst err", 32'(err), 32'd0);
        read_window("rd_after_rst", 16'h0000, 4, 32'hD4C3_E2E1, 0, 1'b0);

        // rx_valid during RD_PRESENT is dropped and the stream is unaffected.
        read_window("rd_poke", 16'h0000, 4, 32'hD4C3_E2E1, 2, 1'b1);
        read_window("rd_after_poke", 16'h0000, 4, 32'hD4C3_E2E1, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gate_test_mem_responder.md
Name: gate_test_mem_responder

Overview:
Memory-side responder to the gate-test controller's command interface.
- Write command (8'h01): stores incoming UART bytes into a small byte memory across an inclusive address window. Pulses rx_done when the window is filled.
- Read command (8'h00): streams the window back out as tx_byte under a valid/ready handshake. Pulses tx_done after the last byte.
- Sits between the UART receive/transmit blocks and the verification controller. Holds DUT stimulus at 0x0008 and DUT results at 0x0000.

Parameters:
- DEPTH, 16, number of 8-bit memory locations; valid addresses are 0..DEPTH-1.
- IDX_W, 4, index width, equal to clog2(DEPTH).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd  in  8  command code: 8'h00 = read, 8'h01 = write.
- cmd_valid  in  1  one-cycle strobe; cmd and addresses are sampled when it is high.
- start_addr  in  16  first address of the window, inclusive.
- end_addr  in  16  last address of the window, inclusive.
- rx_byte  in  8  byte from the UART receiver.
- rx_valid  in  1  one-cycle strobe qualifying rx_byte.
- tx_ready  in  1  downstream (UART transmitter / controller) can accept tx_byte.
- tx_byte  out  8  read data.
- tx_valid  out  1  tx_byte is valid.
- rx_done  out  1  one-cycle pulse: write window complete.
- tx_done  out  1  one-cycle pulse: last read byte accepted.
- busy  out  1  high whenever state is not IDLE.
- err  out  1  one-cycle pulse on a rejected command.

Behaviour:
- Reset: on rst high at a clock edge:
  - state=IDLE, ptr=0.
  - tx_byte=0, tx_valid=0, rx_done=0, tx_done=0, busy=0, err=0.
  - Memory array is NOT cleared.
  - Reset mid-operation abandons the transfer. Bytes already written remain.
- States: IDLE, WRITE, RD_FETCH, RD_PRESENT.
- IDLE:
  - cmd_valid is honoured only in IDLE; cmd_valid in any other state is ignored.
  - On cmd_valid, latch start_addr/end_addr, set ptr=start_addr[IDX_W-1:0].
- Validity: the window is valid if end_addr >= start_addr and end_addr <= DEPTH-1, compared at full 16-bit width.
- Rejection: invalid window, or cmd not in {00,01}: err=1 for one cycle, remain IDLE, memory untouched.
- WRITE (cmd 01):
  - Each cycle with rx_valid=1: mem[ptr]<=rx_byte.
  - If ptr==end: rx_done=1 next cycle, go to IDLE.
  - Otherwise ptr<=ptr+1.
  - rx_valid=0: hold.
  - rx_valid arriving in IDLE or a read state is dropped.
- RD_FETCH (cmd 00):
  - Synchronous memory read of mem[ptr]; one-cycle latency.
  - Next cycle: tx_byte<=data, tx_valid<=1, go to RD_PRESENT.
- RD_PRESENT:
  - tx_byte and tx_valid are held stable while tx_ready=0.
  - On tx_valid&&tx_ready:
    - tx_valid<=0.
    - If ptr==end: tx_done=1 next cycle, go to IDLE.
    - Else ptr<=ptr+1, go to RD_FETCH.
  - Minimum spacing is 2 cycles per byte.
- Latency:
  - cmd_valid (read) to first tx_valid: 2 cycles.
  - Last rx_valid to rx_done: 1 cycle.
  - Last handshake to tx_done: 1 cycle.
- Single-address window (start==end):
  - Write completes after exactly one rx_valid.
  - Read emits exactly one byte.
- Wrap: ptr never wraps; the window check guarantees ptr<=DEPTH-1.
- Pulse outputs: rx_done, tx_done and err are each exactly one cycle wide and never asserted simultaneously.
- busy: high from the cycle after an accepted cmd_valid through the cycle the done pulse is asserted. busy=0 in the cycle err is high.
- tx_byte retains its last value after the transfer; only tx_valid qualifies it.

Test Plan:
- Reset, then write cmd=01, start=end=0x0008, rx_byte=8'b00_01_10_11 with rx_valid -> mem[8]=0x1B, rx_done pulses 1 cycle later, busy low after.
- Read cmd=00, start=end=0x0008, tx_ready held 1 -> tx_byte=0x1B with tx_valid 2 cycles after cmd_valid, tx_done 1 cycle after handshake, exactly one byte.
- Write 0x0000..0x0003 with bytes A1,B2,C3,D4 (gaps between rx_valid), then read the same window with tx_ready low 3 cycles per byte -> bytes A1,B2,C3,D4 in order, tx_byte stable while stalled, one tx_done.
- cmd=8'h05; then cmd=00 with start=4,end=2; then cmd=01 with end=0x0010 -> err pulse each time, busy stays 0, memory unchanged.
- During a write of 0..3, assert cmd_valid again and rx_valid after 2 bytes, then rst -> second command ignored, state IDLE, all outputs 0, mem[0],mem[1] written, mem[2],mem[3] unchanged.
- rx_valid pulses while in RD_PRESENT -> dropped, memory unchanged, read stream unaffected.
